// File: rtl/stft_pkg.sv
// Shared types and width helpers for the STFT frame sequencer.
// Optional feature macro used by the top level: STFT_DROP_COUNT_EN.
package stft_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic {
        IDLE,
        STREAM
    } seq_state_t;

    // Width of the in-frame sample index.
    function automatic int idx_width(input int samples);
        return $clog2(samples);
    endfunction

    // Width of a ring pointer; the ring holds two frames.
    function automatic int ptr_width(input int samples);
        return $clog2(2 * samples);
    endfunction

endpackage

// File: rtl/stft_frame_sequencer_if.sv
// Frame burst stream from the sequencer toward the window/FFT path.
// The master drives index, data, valid and last; the slave returns ready.
interface stft_frame_sequencer_if #(
    parameter int SAMPLES = 512,
    parameter int WIDTH   = 16
);
    import stft_pkg::*;

    localparam int IW = idx_width(SAMPLES);

    logic [IW-1:0]           sample;
    logic signed [WIDTH-1:0] audio_data_out;
    logic                    audio_valid_out;
    logic                    audio_ready_in;
    logic                    frame_last_out;

    modport master (
        output sample,
        output audio_data_out,
        output audio_valid_out,
        output frame_last_out,
        input  audio_ready_in
    );

    modport slave (
        input  sample,
        input  audio_data_out,
        input  audio_valid_out,
        input  frame_last_out,
        output audio_ready_in
    );

endinterface

// File: rtl/audio_ring_buffer.sv
// Simple dual-port sample store with a registered, enable-gated read port.
// No reset on the storage or read register so it maps onto block RAM.
module audio_ring_buffer #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port and registered read; rd_data holds while rd_en is low.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/stft_frame_sequencer.sv
// STFT frame sequencer: rings incoming audio, triggers an overlapped frame
// every HOP samples once a full frame is buffered, and replays each frame
// oldest-first as a valid/ready burst. A trigger arriving while a frame
// streams is held pending; a second one replaces it and sets overrun_out.
// Optional: define STFT_DROP_COUNT_EN to add a saturating dropped_frames_out.
module stft_frame_sequencer
    import stft_pkg::*;
#(
    parameter int SAMPLES = 512,
    parameter int HOP     = 128,
    parameter int WIDTH   = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic signed [WIDTH-1:0] audio_data_in,
    input  logic                    audio_valid_in,
    stft_frame_sequencer_if.master  out_if,
    output logic                    busy_out,
    output logic                    overrun_out
`ifdef STFT_DROP_COUNT_EN
    ,
    output logic [15:0]             dropped_frames_out
`endif
);

    localparam int IW = idx_width(SAMPLES);
    localparam int PW = ptr_width(SAMPLES);

    localparam logic [IW:0]   FILL_FULL  = (IW+1)'(SAMPLES);
    localparam logic [IW:0]   FILL_LAST  = (IW+1)'(SAMPLES - 1);
    localparam logic [IW-1:0] HOP_LAST   = IW'(HOP - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(SAMPLES - 1);
    localparam logic [PW-1:0] FRAME_SPAN = PW'(SAMPLES);

    seq_state_t state, state_n;

    logic [PW-1:0] wr_ptr;
    logic [IW:0]   fill_cnt;
    logic [IW-1:0] hop_cnt;
    logic          trigger;
    logic [PW-1:0] trig_base;

    logic          pending;
    logic [PW-1:0] pending_base;
    logic [PW-1:0] base;
    logic [IW-1:0] rd_idx;
    logic          issue_done;
    logic          issue;

    logic          valid_q;
    logic          last_q;
    logic [IW-1:0] sample_q;
    logic [WIDTH-1:0] ram_q;

    logic          beat_taken;
    logic          last_accept;

    logic          launch;
    logic [PW-1:0] launch_base;
    logic          set_pend;
    logic          clr_pend;
    logic          drop;

    // The base of a new frame is the oldest of the last SAMPLES writes,
    // counting the write happening this cycle.
    assign trigger   = audio_valid_in &&
                       ((fill_cnt == FILL_LAST) ||
                        ((fill_cnt == FILL_FULL) && (hop_cnt == HOP_LAST)));
    assign trig_base = wr_ptr + PW'(1) - FRAME_SPAN;

    assign beat_taken  = valid_q && out_if.audio_ready_in;
    assign last_accept = beat_taken && last_q;
    assign issue       = (state == STREAM) && !issue_done &&
                         (!valid_q || out_if.audio_ready_in);

    audio_ring_buffer #(
        .DEPTH (2 * SAMPLES),
        .WIDTH (WIDTH),
        .AW    (PW)
    ) u_ring (
        .clk_in  (clk_in),
        .wr_en   (audio_valid_in),
        .wr_addr (wr_ptr),
        .wr_data (audio_data_in),
        .rd_en   (issue),
        .rd_addr (base + {1'b0, rd_idx}),
        .rd_data (ram_q)
    );

    // Write pointer, fill level and hop spacing of the incoming stream.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr   <= '0;
            fill_cnt <= '0;
            hop_cnt  <= '0;
        end else if (audio_valid_in) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (fill_cnt != FILL_FULL) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            if (trigger) begin
                hop_cnt <= '0;
            end else if (fill_cnt == FILL_FULL) begin
                hop_cnt <= hop_cnt + 1'b1;
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state plus frame launch and pending/drop decisions.
    always_comb begin
        state_n     = state;
        launch      = 1'b0;
        launch_base = trig_base;
        set_pend    = 1'b0;
        clr_pend    = 1'b0;
        drop        = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    launch      = 1'b1;
                    launch_base = pending_base;
                    clr_pend    = 1'b1;
                    set_pend    = trigger;
                    state_n     = STREAM;
                end else if (trigger) begin
                    launch  = 1'b1;
                    state_n = STREAM;
                end
            end
            STREAM: begin
                if (last_accept) begin
                    if (pending) begin
                        launch      = 1'b1;
                        launch_base = pending_base;
                        clr_pend    = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
                if (trigger) begin
                    set_pend = 1'b1;
                    drop     = pending && !clr_pend;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Frame read cursor: reload on launch, advance on every issued read.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            base       <= '0;
            rd_idx     <= '0;
            issue_done <= 1'b0;
        end else if (launch) begin
            base       <= launch_base;
            rd_idx     <= '0;
            issue_done <= 1'b0;
        end else if (issue) begin
            rd_idx <= rd_idx + 1'b1;
            if (rd_idx == IDX_LAST) begin
                issue_done <= 1'b1;
            end
        end
    end

    // Output beat register, kept in step with the RAM read register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            sample_q <= '0;
        end else if (issue) begin
            valid_q  <= 1'b1;
            last_q   <= (rd_idx == IDX_LAST);
            sample_q <= rd_idx;
        end else if (beat_taken) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    // Pending frame slot and sticky overrun flag.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pending      <= 1'b0;
            pending_base <= '0;
            overrun_out  <= 1'b0;
        end else begin
            if (set_pend) begin
                pending      <= 1'b1;
                pending_base <= trig_base;
            end else if (clr_pend) begin
                pending <= 1'b0;
            end
            if (drop) begin
                overrun_out <= 1'b1;
            end
        end
    end

`ifdef STFT_DROP_COUNT_EN
    // Saturating count of triggers lost to the pending slot being overwritten.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dropped_frames_out <= '0;
        end else if (drop && (dropped_frames_out != 16'hFFFF)) begin
            dropped_frames_out <= dropped_frames_out + 1'b1;
        end
    end
`endif

    // The RAM register is not reset, so data is masked to zero when no beat is held.
    assign out_if.audio_valid_out = valid_q;
    assign out_if.frame_last_out  = last_q;
    assign out_if.sample          = sample_q;
    assign out_if.audio_data_out  = valid_q ? $signed(ram_q) : '0;
    assign busy_out               = (state == STREAM);

endmodule

// File: tb/tb_stft_frame_sequencer.sv
// Self-checking bench for stft_frame_sequencer with SAMPLES=8, HOP=4.
// Expected frames are queued as the writes that trigger them are driven and
// compared beat by beat whenever the DUT hands over an accepted beat.
module tb_stft_frame_sequencer;

    localparam int SAMPLES = 8;
    localparam int HOP     = 4;
    localparam int WIDTH   = 16;

    typedef struct {
        logic [2:0]         idx;
        logic signed [15:0] data;
        logic               last;
    } beat_t;

    logic                    clk;
    logic                    rst;
    logic signed [WIDTH-1:0] audio_data_in;
    logic                    audio_valid_in;
    logic                    busy;
    logic                    overrun;
`ifdef STFT_DROP_COUNT_EN
    logic [15:0]             dropped_frames;
`endif

    int    tests_run    = 0;
    int    tests_failed = 0;
    beat_t sb_q[$];

    stft_frame_sequencer_if #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) out_if ();

    stft_frame_sequencer #(
        .SAMPLES (SAMPLES),
        .HOP     (HOP),
        .WIDTH   (WIDTH)
    ) dut (
        .clk_in             (clk),
        .rst_in             (rst),
        .audio_data_in      (audio_data_in),
        .audio_valid_in     (audio_valid_in),
        .out_if             (out_if),
        .busy_out           (busy),
        .overrun_out        (overrun)
`ifdef STFT_DROP_COUNT_EN
        ,
        .dropped_frames_out (dropped_frames)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: every beat accepted at the coming edge must match the queue head.
    always @(negedge clk) begin
        if (!rst && out_if.audio_valid_out && out_if.audio_ready_in) begin
            tests_run++;
            if (sb_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_beat: got sample=%0d data=%0d, required no beat",
                         out_if.sample, out_if.audio_data_out);
            end else begin
                beat_t exp;
                exp = sb_q.pop_front();
                if (out_if.sample !== exp.idx || out_if.audio_data_out !== exp.data ||
                    out_if.frame_last_out !== exp.last) begin
                    tests_failed++;
                    $display("[TB] FAIL beat: got sample=%0d data=%0d last=%0b, required sample=%0d data=%0d last=%0b",
                             out_if.sample, out_if.audio_data_out, out_if.frame_last_out,
                             exp.idx, exp.data, exp.last);
                end
            end
        end
    end

    // All stimulus tasks start and end 1ns after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_sample(input int v);
        audio_data_in  = 16'(v);
        audio_valid_in = 1'b1;
        @(posedge clk);
        #1;
        audio_valid_in = 1'b0;
    endtask

    task automatic push_frame(input int first);
        for (int i = 0; i < SAMPLES; i++) begin
            beat_t b;
            b.idx  = 3'(i);
            b.data = 16'(first + i);
            b.last = (i == SAMPLES - 1);
            sb_q.push_back(b);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
    endtask

    task automatic wait_beat(input int idx, output logic ok);
        int n = 0;
        while (!(out_if.audio_valid_out === 1'b1 && out_if.sample === 3'(idx)) && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = (n < 30);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (out_if.audio_valid_out !== 1'b0 || out_if.sample !== 3'd0 ||
            out_if.audio_data_out !== 16'sd0 || out_if.frame_last_out !== 1'b0 ||
            busy !== 1'b0 || overrun !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got valid=%0b sample=%0d data=%0d last=%0b busy=%0b overrun=%0b, required all 0",
                     out_if.audio_valid_out, out_if.sample, out_if.audio_data_out,
                     out_if.frame_last_out, busy, overrun);
        end
`ifdef STFT_DROP_COUNT_EN
        tests_run++;
        if (dropped_frames !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_dropped: got %0d, required 0", dropped_frames);
        end
`endif
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_fill();
        for (int v = 1; v <= 7; v++) begin
            write_sample(v);
            idle(9);
        end
        tests_run++;
        if (out_if.audio_valid_out !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL no_early_frame: got valid=%0b busy=%0b, required 0 0",
                     out_if.audio_valid_out, busy);
        end
        push_frame(1);
        write_sample(8);
        tests_run++;
        if (out_if.audio_valid_out !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL latency_cycle1: got valid=%0b busy=%0b, required 0 1",
                     out_if.audio_valid_out, busy);
        end
        idle(1);
        tests_run++;
        if (out_if.audio_valid_out !== 1'b1 || out_if.sample !== 3'd0 ||
            out_if.audio_data_out !== 16'sd1) begin
            tests_failed++;
            $display("[TB] FAIL latency_cycle2: got valid=%0b sample=%0d data=%0d, required 1 0 1",
                     out_if.audio_valid_out, out_if.sample, out_if.audio_data_out);
        end
        wait_drain(40);
        tests_run++;
        if (sb_q.size() !== 0) begin
            tests_failed++;
            $display("[TB] FAIL fill_drain: got %0d beats left, required 0", sb_q.size());
        end
    endtask

    task automatic test_hop();
        for (int v = 9; v <= 11; v++) begin
            write_sample(v);
            idle(9);
        end
        push_frame(5);
        write_sample(12);
        wait_drain(40);
        tests_run++;
        if (sb_q.size() !== 0) begin
            tests_failed++;
            $display("[TB] FAIL hop_drain: got %0d beats left, required 0", sb_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic ok;
        for (int v = 13; v <= 15; v++) begin
            write_sample(v);
            idle(9);
        end
        push_frame(9);
        write_sample(16);
        wait_beat(3, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL bp_reach_beat3: got timeout, required beat 3 within 30 cycles");
        end
        out_if.audio_ready_in = 1'b0;
        for (int c = 0; c < 5; c++) begin
            idle(1);
            tests_run++;
            if (out_if.audio_valid_out !== 1'b1 || out_if.sample !== 3'd3 ||
                out_if.audio_data_out !== 16'sd12 || out_if.frame_last_out !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL bp_hold: got valid=%0b sample=%0d data=%0d last=%0b, required 1 3 12 0",
                         out_if.audio_valid_out, out_if.sample, out_if.audio_data_out,
                         out_if.frame_last_out);
            end
        end
        out_if.audio_ready_in = 1'b1;
        wait_drain(40);
        tests_run++;
        if (sb_q.size() !== 0) begin
            tests_failed++;
            $display("[TB] FAIL bp_drain: got %0d beats left, required 0", sb_q.size());
        end
    endtask

    task automatic test_edge_trigger();
        for (int v = 17; v <= 19; v++) begin
            write_sample(v);
            idle(9);
        end
        push_frame(13);
        write_sample(20);
        idle(2);
        write_sample(21);
        idle(1);
        write_sample(22);
        idle(1);
        write_sample(23);
        idle(1);
        tests_run++;
        if (out_if.audio_valid_out !== 1'b1 || out_if.frame_last_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL edge_align: got valid=%0b last=%0b, required 1 1",
                     out_if.audio_valid_out, out_if.frame_last_out);
        end
        push_frame(17);
        write_sample(24);
        wait_drain(40);
        tests_run++;
        if (sb_q.size() !== 0 || overrun !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL edge_no_loss: got %0d beats left overrun=%0b, required 0 0",
                     sb_q.size(), overrun);
        end
    endtask

    task automatic test_overrun();
        for (int v = 25; v <= 27; v++) begin
            write_sample(v);
            idle(9);
        end
        push_frame(21);
        write_sample(28);
        out_if.audio_ready_in = 1'b0;
        for (int v = 29; v <= 36; v++) begin
            if (v == 36) push_frame(29);
            write_sample(v);
            idle(9);
        end
        idle(20);
        tests_run++;
        if (overrun !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL overrun_flag: got %0b, required 1", overrun);
        end
`ifdef STFT_DROP_COUNT_EN
        tests_run++;
        if (dropped_frames !== 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL dropped_count: got %0d, required 1", dropped_frames);
        end
`endif
        tests_run++;
        if (out_if.audio_valid_out !== 1'b1 || out_if.sample !== 3'd0 ||
            out_if.audio_data_out !== 16'sd21) begin
            tests_failed++;
            $display("[TB] FAIL overrun_stall_hold: got valid=%0b sample=%0d data=%0d, required 1 0 21",
                     out_if.audio_valid_out, out_if.sample, out_if.audio_data_out);
        end
        out_if.audio_ready_in = 1'b1;
        wait_drain(60);
        tests_run++;
        if (sb_q.size() !== 0 || overrun !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL overrun_drain: got %0d beats left overrun=%0b, required 0 1",
                     sb_q.size(), overrun);
        end
    endtask

    task automatic test_mid_reset();
        logic ok;
        for (int v = 37; v <= 39; v++) begin
            write_sample(v);
            idle(9);
        end
        push_frame(33);
        write_sample(40);
        wait_beat(4, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL rst_reach_beat4: got timeout, required beat 4 within 30 cycles");
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (out_if.audio_valid_out !== 1'b0 || out_if.sample !== 3'd0 ||
            out_if.audio_data_out !== 16'sd0 || out_if.frame_last_out !== 1'b0 ||
            busy !== 1'b0 || overrun !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midframe_reset: got valid=%0b sample=%0d data=%0d last=%0b busy=%0b overrun=%0b, required all 0",
                     out_if.audio_valid_out, out_if.sample, out_if.audio_data_out,
                     out_if.frame_last_out, busy, overrun);
        end
`ifdef STFT_DROP_COUNT_EN
        tests_run++;
        if (dropped_frames !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL midframe_reset_dropped: got %0d, required 0", dropped_frames);
        end
`endif
        sb_q.delete();
        idle(2);
        rst = 1'b0;
        idle(1);
        for (int v = 41; v <= 47; v++) begin
            write_sample(v);
            idle(9);
        end
        tests_run++;
        if (out_if.audio_valid_out !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL refill_required: got valid=%0b busy=%0b, required 0 0",
                     out_if.audio_valid_out, busy);
        end
        push_frame(41);
        write_sample(48);
        wait_drain(40);
        tests_run++;
        if (sb_q.size() !== 0) begin
            tests_failed++;
            $display("[TB] FAIL refill_drain: got %0d beats left, required 0", sb_q.size());
        end
    endtask

    initial begin
        rst                   = 1'b1;
        audio_data_in         = '0;
        audio_valid_in        = 1'b0;
        out_if.audio_ready_in = 1'b1;
        test_reset();
        test_fill();
        test_hop();
        test_backpressure();
        test_edge_trigger();
        test_overrun();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/stft_frame_sequencer.md
Name: stft_frame_sequencer

Overview:
- Sits between the audio sample stream and hanning_window, ahead of the FFT.
- Buffers incoming samples in a ring buffer and triggers an overlapped frame every HOP new samples, once the first SAMPLES samples have arrived.
- Replays each frame oldest-first as a burst: `sample` index 0..SAMPLES-1 plus data, with valid/ready toward the window/FFT path.
- Flags frames lost to downstream stalls.

Parameters:
- SAMPLES, 512: frame length; power of two, >=4.
- HOP, 128: new samples between frame triggers; 1 <= HOP <= SAMPLES, divides SAMPLES.
- WIDTH, 16: signed sample width.

Ports:
- clk_in  in  1  system clock (100 MHz).
- rst_in  in  1  asynchronous, active-high reset.
- audio_data_in  in  WIDTH  signed input sample.
- audio_valid_in  in  1  single-cycle strobe, one sample per assertion.
- sample  out  $clog2(SAMPLES)  index within frame; drives hanning_window `sample`.
- audio_data_out  out  WIDTH  buffered sample for that index.
- audio_valid_out  out  1  output beat valid.
- audio_ready_in  in  1  downstream accepts beat.
- frame_last_out  out  1  high with the beat at index SAMPLES-1.
- busy_out  out  1  high while a frame is streaming (state STREAM).
- overrun_out  out  1  sticky; a trigger was dropped.

Behaviour:
- Reset values: all outputs 0. Internal state:
  - wr_ptr 0, fill_cnt 0, hop_cnt 0, pending 0, state IDLE.
  - Ring contents are undefined, but are never read before being written.
- Ring buffer: depth 2*SAMPLES, 1-cycle registered read. Every audio_valid_in writes at wr_ptr, then wr_ptr+1 mod 2*SAMPLES. Writes proceed in every state.
- fill_cnt: saturates at SAMPLES.
- hop_cnt: counts writes only once fill_cnt == SAMPLES.
- Trigger: a single-cycle trigger fires on the write that makes fill_cnt reach SAMPLES (first frame), and thereafter on every HOP-th write. hop_cnt clears on trigger.
- Frame base: base = (wr_ptr_after_write - SAMPLES) mod 2*SAMPLES, latched at trigger.
- States:
  - IDLE: trigger, or pending set, -> STREAM. Load rd_idx=0 and the base (pending base if pending). Clear pending.
  - STREAM: issue read at base+rd_idx whenever the output register is empty or being consumed (audio_valid_out && audio_ready_in).
    - First audio_valid_out occurs 2 cycles after the trigger.
    - With audio_ready_in held high, one beat per cycle; a frame is SAMPLES consecutive beats.
    - The beat at rd_idx = SAMPLES-1 asserts frame_last_out.
    - When that beat is accepted -> IDLE, or directly back into STREAM (no bubble state) if pending.
- Backpressure: while audio_valid_out && !audio_ready_in, sample, audio_data_out and frame_last_out hold stable and no read is issued.
- Trigger in STREAM: set pending and latch pending base.
- Trigger while pending already set: overwrite pending base with the newer frame and set overrun_out (the older pending frame is dropped). The current streaming frame is never aborted.
- A trigger in the same cycle the last beat is accepted counts as pending (handled next cycle, no loss).
- overrun_out: cleared only by rst_in.
- Reset mid-frame: asynchronously clears all of the above; the next frame needs a full refill of SAMPLES samples.

Optional Feature:
- Macro STFT_DROP_COUNT_EN.
- Defined: adds output port dropped_frames_out [15:0]. It counts every dropped trigger, saturates at 16'hFFFF, and resets to 0.
- Undefined: port and counter absent; overrun_out behaviour unchanged.

Decomposition:
- Package stft_pkg holds:
  - typedef sample_t (logic signed [15:0]);
  - enum seq_state_t {IDLE, STREAM};
  - localparam functions for index and pointer widths from SAMPLES.
- One sub-module: audio_ring_buffer (simple dual-port, 2*SAMPLES x WIDTH, registered read) to map to BRAM.

Test Plan:
All scenarios use SAMPLES=8, HOP=4, with writes of ramp values 1,2,3,... one every 10 cycles, unless stated otherwise.
- Reset/fill: 7 writes -> no audio_valid_out. 8th write -> 2 cycles later 8 beats, sample 0..7, data 1..8, frame_last_out on beat 7.
- Hop overlap: 4 further writes (9..12) -> next frame data 5..12, sample 0..7.
- Backpressure: audio_ready_in low for 5 cycles at beat 3 -> sample=3, data=4 held stable. Resumes with no repeated or skipped beats.
- Overrun: audio_ready_in low 100 cycles during frame 1, with 8 more writes (two triggers) -> overrun_out=1. Next frame streamed is the newest (data 9..16). With STFT_DROP_COUNT_EN, dropped_frames_out=1.
- Edge trigger: a trigger coincides with acceptance of beat 7 -> next frame starts with no loss, overrun_out stays 0.
- Mid-frame reset: pulse rst_in at beat 4 -> all outputs 0 immediately. Next frame only after 8 new writes.
